// File: rtl/udp_tx_pkg.sv
// rtl/udp_tx_pkg.sv - shared header sizes, protocol constants, state type and ones-complement add
package udp_tx_pkg;

    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;
    localparam int HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DROP,
        CSUM,
        HEADER,
        PAYLOAD,
        GAP
    } tx_state_t;

    // 16-bit add with the carry folded back in; one fold suffices for two 16-bit operands
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/udp_tx_payload_buf.sv
// rtl/udp_tx_payload_buf.sv - payload byte store with write count and read pointer
module udp_tx_payload_buf #(
    parameter int MAX_PAYLOAD = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] count,
    output logic [7:0] rd_idx,
    output logic [7:0] rd_data
);

    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    logic [7:0] mem [0:(1 << AW) - 1];

    assign rd_data = mem[rd_idx[AW-1:0]];

    // storage is not reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    // count doubles as the write pointer; clr restarts both pointers for the next frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 8'd0;
            rd_idx <= 8'd0;
        end else if (clr) begin
            count  <= 8'd0;
            rd_idx <= 8'd0;
        end else begin
            if (wr_en) count  <= count + 8'd1;
            if (rd_en) rd_idx <= rd_idx + 8'd1;
        end
    end

endmodule

// File: rtl/udp_packet_builder.sv
// rtl/udp_packet_builder.sv - buffers a payload and emits an Ethernet/IPv4/UDP frame; UDP_CHECKSUM_EN adds the UDP checksum
module udp_packet_builder
    import udp_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 32,
    parameter logic [7:0] IP_TTL      = 8'h40,
    parameter int         IFG_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [31:0] cfg_src_ip,
    input  logic [31:0] cfg_dst_ip,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        tx_busy,
    output logic        frame_sent,
    output logic        overflow
);

    localparam int          HDR_BITS     = HDR_LEN * 8;
    localparam logic [7:0]  MAX_LEN      = 8'(MAX_PAYLOAD);
    localparam logic [7:0]  HDR_LAST     = 8'(HDR_LEN - 1);
    localparam logic [7:0]  IFG_LAST     = 8'(IFG_CYCLES - 1);
    localparam logic [15:0] IP_BASE_LEN  = 16'(IP_HDR_LEN + UDP_HDR_LEN);
    localparam logic [15:0] UDP_BASE_LEN = 16'(UDP_HDR_LEN);

    tx_state_t   state;
    logic [7:0]  cnt;
    logic [7:0]  n_len;
    logic [15:0] ip_id;
    logic [15:0] ip_csum;
    logic [15:0] udp_csum;
    logic [15:0] ip_sum;
    logic [47:0] lat_dst_mac, lat_src_mac;
    logic [31:0] lat_src_ip, lat_dst_ip;
    logic [15:0] lat_src_port, lat_dst_port;
    logic [15:0] total_len, udp_len;
    logic [HDR_BITS-1:0] hdr, hdr_sh;

    logic       buf_wr_en, buf_rd_en, buf_clr;
    logic [7:0] buf_count, buf_rd_idx, buf_rd_data;

    assign in_ready  = (state == IDLE) || (state == COLLECT) || (state == DROP);
    assign tx_busy   = (state != IDLE);
    assign buf_wr_en = in_valid && ((state == IDLE) || ((state == COLLECT) && (buf_count != MAX_LEN)));
    assign buf_rd_en = (state == PAYLOAD);
    assign buf_clr   = (state == DROP) || (state == GAP);

    udp_tx_payload_buf #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr_en),
        .wr_data (in_data),
        .rd_en   (buf_rd_en),
        .count   (buf_count),
        .rd_idx  (buf_rd_idx),
        .rd_data (buf_rd_data)
    );

    assign total_len = IP_BASE_LEN + {8'd0, n_len};
    assign udp_len   = UDP_BASE_LEN + {8'd0, n_len};

    // the whole 42-byte header as one vector; the FSM shifts it to pick the current byte
    assign hdr = {lat_dst_mac, lat_src_mac, ETHERTYPE_IPV4,
                  16'h4500, total_len, ip_id, 16'h4000, IP_TTL, IP_PROTO_UDP, ip_csum,
                  lat_src_ip, lat_dst_ip,
                  lat_src_port, lat_dst_port, udp_len, udp_csum};
    assign hdr_sh = hdr << {cnt, 3'b000};

    // IPv4 header sum over the ten words with the checksum word taken as zero
    always_comb begin
        ip_sum = ones_add(16'h4500, total_len);
        ip_sum = ones_add(ip_sum, ip_id);
        ip_sum = ones_add(ip_sum, 16'h4000);
        ip_sum = ones_add(ip_sum, {IP_TTL, IP_PROTO_UDP});
        ip_sum = ones_add(ip_sum, lat_src_ip[31:16]);
        ip_sum = ones_add(ip_sum, lat_src_ip[15:0]);
        ip_sum = ones_add(ip_sum, lat_dst_ip[31:16]);
        ip_sum = ones_add(ip_sum, lat_dst_ip[15:0]);
    end

`ifdef UDP_CHECKSUM_EN
    logic [15:0] pay_sum;
    logic [15:0] udp_sum;

    // running payload sum: even offsets land in the high byte, so an odd tail is padded low with zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pay_sum <= 16'h0000;
        end else if (buf_wr_en) begin
            if (state == IDLE) pay_sum <= {in_data, 8'h00};
            else               pay_sum <= ones_add(pay_sum, buf_count[0] ? {8'h00, in_data} : {in_data, 8'h00});
        end
    end

    // pseudo-header plus UDP header words folded onto the payload sum
    always_comb begin
        udp_sum = ones_add(pay_sum, lat_src_ip[31:16]);
        udp_sum = ones_add(udp_sum, lat_src_ip[15:0]);
        udp_sum = ones_add(udp_sum, lat_dst_ip[31:16]);
        udp_sum = ones_add(udp_sum, lat_dst_ip[15:0]);
        udp_sum = ones_add(udp_sum, {8'h00, IP_PROTO_UDP});
        udp_sum = ones_add(udp_sum, udp_len);
        udp_sum = ones_add(udp_sum, lat_src_port);
        udp_sum = ones_add(udp_sum, lat_dst_port);
        udp_sum = ones_add(udp_sum, udp_len);
    end

    // a computed zero is sent as FFFF because zero on the wire means no checksum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           udp_csum <= 16'h0000;
        else if (state == CSUM) udp_csum <= (udp_sum == 16'hFFFF) ? 16'hFFFF : ~udp_sum;
    end
`else
    assign udp_csum = 16'h0000;
`endif

    // frame sequencer: collect, checksum, stream header then payload, then hold off for the gap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            n_len        <= 8'd0;
            ip_id        <= 16'h0000;
            ip_csum      <= 16'h0000;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            frame_sent   <= 1'b0;
            overflow     <= 1'b0;
            lat_dst_mac  <= 48'd0;
            lat_src_mac  <= 48'd0;
            lat_src_ip   <= 32'd0;
            lat_dst_ip   <= 32'd0;
            lat_src_port <= 16'd0;
            lat_dst_port <= 16'd0;
        end else begin
            frame_sent <= 1'b0;
            overflow   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) state <= COLLECT;
                end
                COLLECT: begin
                    if (!in_valid) begin
                        state        <= CSUM;
                        n_len        <= buf_count;
                        lat_dst_mac  <= cfg_dst_mac;
                        lat_src_mac  <= cfg_src_mac;
                        lat_src_ip   <= cfg_src_ip;
                        lat_dst_ip   <= cfg_dst_ip;
                        lat_src_port <= cfg_src_port;
                        lat_dst_port <= cfg_dst_port;
                    end else if (buf_count == MAX_LEN) begin
                        overflow <= 1'b1;
                        state    <= DROP;
                    end
                end
                DROP: begin
                    if (!in_valid) state <= IDLE;
                end
                CSUM: begin
                    ip_csum <= ~ip_sum;
                    cnt     <= 8'd0;
                    state   <= HEADER;
                end
                HEADER: begin
                    out_valid <= 1'b1;
                    out_data  <= hdr_sh[HDR_BITS-1 -: 8];
                    if (cnt == HDR_LAST) begin
                        cnt   <= 8'd0;
                        state <= PAYLOAD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PAYLOAD: begin
                    out_valid <= 1'b1;
                    out_data  <= buf_rd_data;
                    if (buf_rd_idx == n_len - 8'd1) state <= GAP;
                end
                GAP: begin
                    out_valid <= 1'b0;
                    out_data  <= 8'h00;
                    if (cnt == 8'd0) begin
                        frame_sent <= 1'b1;
                        ip_id      <= ip_id + 16'd1;
                    end
                    if (cnt == IFG_LAST) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_packet_builder.sv
// tb/tb_udp_packet_builder.sv - randomized self-checking bench for udp_packet_builder against a frame-level model
`timescale 1ns/1ps
module tb_udp_packet_builder;

    localparam int MAXP = 32;
    localparam int IFG  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, out_valid, tx_busy, frame_sent, overflow;
    logic [7:0]  out_data;
    logic [47:0] cfg_dst_mac, cfg_src_mac;
    logic [31:0] cfg_src_ip, cfg_dst_ip;
    logic [15:0] cfg_src_port, cfg_dst_port;

    int tests = 0;
    int failed = 0;
    logic [7:0] pay_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int rx_base = 0;
    logic [15:0] exp_id = 16'h0000;
    int bad_idle = 0, bad_fs = 0, ovf_cnt = 0, idle_run = 0, last_gap = 0;

    always #5 clk = ~clk;

    udp_packet_builder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .cfg_dst_mac  (cfg_dst_mac),
        .cfg_src_mac  (cfg_src_mac),
        .cfg_src_ip   (cfg_src_ip),
        .cfg_dst_ip   (cfg_dst_ip),
        .cfg_src_port (cfg_src_port),
        .cfg_dst_port (cfg_dst_port),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .tx_busy      (tx_busy),
        .frame_sent   (frame_sent),
        .overflow     (overflow)
    );

    // line-side monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (out_valid) begin
            rx_q.push_back(out_data);
            if (idle_run != 0) last_gap = idle_run;
            idle_run = 0;
        end else begin
            idle_run++;
            if (reset_n && out_data !== 8'h00) bad_idle++;
        end
        if (frame_sent && out_valid) bad_fs++;
        if (overflow) ovf_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] fold(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        while (t > 32'h0000FFFF) t = (t & 32'h0000FFFF) + (t >> 16);
        return t[15:0];
    endfunction

    function automatic void put(input logic [63:0] v, input int nb);
        for (int k = nb - 1; k >= 0; k--) exp_q.push_back(v[8*k +: 8]);
    endfunction

    // reference frame built straight from the wire format
    function automatic void build_frame(input logic [15:0] id);
        int n;
        logic [15:0] tl, ul, ipc, uc;
        logic [31:0] s;
        n  = pay_q.size();
        tl = 16'(28 + n);
        ul = 16'(8 + n);
        s  = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011
           + 32'(cfg_src_ip[31:16]) + 32'(cfg_src_ip[15:0])
           + 32'(cfg_dst_ip[31:16]) + 32'(cfg_dst_ip[15:0]);
        ipc = ~fold(s);
        uc  = 16'h0000;
`ifdef UDP_CHECKSUM_EN
        s = 32'(cfg_src_ip[31:16]) + 32'(cfg_src_ip[15:0]) + 32'(cfg_dst_ip[31:16]) + 32'(cfg_dst_ip[15:0])
          + 32'h11 + 32'(ul) + 32'(cfg_src_port) + 32'(cfg_dst_port) + 32'(ul);
        for (int i = 0; i < n; i += 2) s += 32'({pay_q[i], (i + 1 < n) ? pay_q[i+1] : 8'h00});
        uc = ~fold(s);
        if (uc == 16'h0000) uc = 16'hFFFF;
`endif
        exp_q.delete();
        put(64'(cfg_dst_mac), 6); put(64'(cfg_src_mac), 6); put(64'h0800, 2);
        put(64'h4500, 2); put(64'(tl), 2); put(64'(id), 2); put(64'h4000, 2); put(64'h4011, 2);
        put(64'(ipc), 2); put(64'(cfg_src_ip), 4); put(64'(cfg_dst_ip), 4);
        put(64'(cfg_src_port), 2); put(64'(cfg_dst_port), 2); put(64'(ul), 2); put(64'(uc), 2);
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    endfunction

    function automatic int rx_len();
        return rx_q.size() - rx_base;
    endfunction

    function automatic logic [15:0] rx16(input int i);
        if (rx_base + i + 1 < rx_q.size()) return {rx_q[rx_base+i], rx_q[rx_base+i+1]};
        return 16'hxxxx;
    endfunction

    function automatic int frame_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (rx_base + i >= rx_q.size() || rx_q[rx_base+i] !== exp_q[i]) return i;
        if (rx_len() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic set_directed();
        cfg_dst_mac  = 48'hFFFF_FFFF_FFFF;
        cfg_src_mac  = 48'h1122_3344_5566;
        cfg_src_ip   = 32'h0A00_0001;
        cfg_dst_ip   = 32'h0A00_0002;
        cfg_src_port = 16'hC0DE;
        cfg_dst_port = 16'h04D2;
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFE, 8'hED, 8'hCA, 8'hFE};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        exp_id = 16'h0000;
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!tx_busy && in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_sent(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_sent) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send_frame();
        rx_base = rx_q.size();
        foreach (pay_q[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pay_q[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({out_valid, in_ready, tx_busy, frame_sent, overflow} !== 5'b01000) begin
            failed++;
            $display("FAIL reset_flags: got v/rdy/busy/sent/ovf=%b, want 01000", {out_valid, in_ready, tx_busy, frame_sent, overflow});
        end
        tests++;
        if (out_data !== 8'h00) begin failed++; $display("FAIL reset_data: got %h, want 00", out_data); end
    endtask

    task automatic test_directed();
        bit ok;
        set_directed();
        wait_idle(ok);
        build_frame(exp_id);
        send_frame();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL latency_early: out_valid got %b one edge after CSUM, want 0", out_valid); end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin failed++; $display("FAIL latency: out_valid got %b two edges after end of payload, want 1", out_valid); end
        tests++;
        if ({in_ready, tx_busy} !== 2'b01) begin failed++; $display("FAIL busy_flags: got rdy/busy=%b, want 01", {in_ready, tx_busy}); end
        wait_sent(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL directed_sent: got no frame_sent, want pulse"); end
        tests++;
        if (rx_len() != 50) begin failed++; $display("FAIL directed_len: got %0d, want 50", rx_len()); end
        tests++;
        if ({rx16(16), rx16(18), rx16(24), rx16(38)} !== 64'h0024_0000_26C7_0010) begin
            failed++;
            $display("FAIL directed_fields: got %h, want 0024000026c70010", {rx16(16), rx16(18), rx16(24), rx16(38)});
        end
`ifndef UDP_CHECKSUM_EN
        tests++;
        if (rx16(40) !== 16'h0000) begin failed++; $display("FAIL directed_udp_csum: got %h, want 0000", rx16(40)); end
`endif
        tests++;
        if (frame_diff() != -1) begin failed++; $display("FAIL directed_frame: first diff at byte %0d of %0d, want none", frame_diff(), rx_len()); end
        exp_id = exp_id + 16'd1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_idle(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL b2b_ready: got busy, want idle"); end
        build_frame(exp_id);
        send_frame();
        wait_sent(ok);
        tests++;
        if ({rx16(18), rx16(24)} !== 32'h0001_26C6) begin failed++; $display("FAIL b2b_fields: got %h, want 000126c6", {rx16(18), rx16(24)}); end
        tests++;
        if (frame_diff() != -1) begin failed++; $display("FAIL b2b_frame: first diff at byte %0d, want none", frame_diff()); end
        tests++;
        if (last_gap < IFG) begin failed++; $display("FAIL b2b_gap: got %0d idle cycles, want >= %0d", last_gap, IFG); end
        exp_id = exp_id + 16'd1;
    endtask

    task automatic test_max_payload();
        bit ok;
        pay_q.delete();
        for (int i = 0; i < MAXP; i++) pay_q.push_back(8'(i));
        wait_idle(ok);
        build_frame(exp_id);
        send_frame();
        wait_sent(ok);
        tests++;
        if (rx_len() != 74 || rx16(38) !== 16'h0028) begin failed++; $display("FAIL max_len: got %0d bytes udp_len %h, want 74 and 0028", rx_len(), rx16(38)); end
        tests++;
        if (frame_diff() != -1) begin failed++; $display("FAIL max_frame: first diff at byte %0d, want none", frame_diff()); end
        exp_id = exp_id + 16'd1;
    endtask

    task automatic test_cfg_change();
        bit ok;
        set_directed();
        wait_idle(ok);
        build_frame(exp_id);
        send_frame();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        cfg_dst_port = 16'h04D3;
        wait_sent(ok);
        tests++;
        if (rx16(36) !== 16'h04D2 || frame_diff() != -1) begin failed++; $display("FAIL cfg_inflight: got dst_port %h diff %0d, want 04d2 and -1", rx16(36), frame_diff()); end
        exp_id = exp_id + 16'd1;
        wait_idle(ok);
        build_frame(exp_id);
        send_frame();
        wait_sent(ok);
        tests++;
        if (rx16(36) !== 16'h04D3 || frame_diff() != -1) begin failed++; $display("FAIL cfg_next: got dst_port %h diff %0d, want 04d3 and -1", rx16(36), frame_diff()); end
        exp_id = exp_id + 16'd1;
    endtask

    task automatic test_random();
        bit ok;
        for (int f = 0; f < 6; f++) begin
            cfg_dst_mac  = 48'({$urandom(), $urandom()});
            cfg_src_mac  = 48'({$urandom(), $urandom()});
            cfg_src_ip   = $urandom();
            cfg_dst_ip   = $urandom();
            cfg_src_port = 16'($urandom());
            cfg_dst_port = 16'($urandom());
            pay_q.delete();
            for (int i = 0; i < int'($urandom_range(MAXP, 1)); i++) pay_q.push_back(8'($urandom()));
            wait_idle(ok);
            build_frame(exp_id);
            send_frame();
            wait_sent(ok);
            tests++;
            if (!ok || frame_diff() != -1) begin
                failed++;
                $display("FAIL random_frame%0d: got %0d bytes first diff %0d, want %0d bytes no diff", f, rx_len(), frame_diff(), exp_q.size());
            end
            exp_id = exp_id + 16'd1;
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int ovf0;
        do_reset();
        set_directed();
        pay_q.delete();
        for (int i = 0; i < MAXP + 1; i++) pay_q.push_back(8'($urandom()));
        wait_idle(ok);
        ovf0 = ovf_cnt;
        send_frame();
        repeat (60) @(negedge clk);
        tests++;
        if (ovf_cnt - ovf0 != 1) begin failed++; $display("FAIL ovf_pulse: got %0d pulses, want 1", ovf_cnt - ovf0); end
        tests++;
        if (rx_len() != 0) begin failed++; $display("FAIL ovf_silent: got %0d output bytes, want 0", rx_len()); end
        pay_q = '{8'h5A};
        wait_idle(ok);
        build_frame(exp_id);
        send_frame();
        wait_sent(ok);
        tests++;
        if ({rx16(16), rx16(18)} !== 32'h001D_0000 || frame_diff() != -1) begin
            failed++;
            $display("FAIL ovf_next: got len/id %h diff %0d, want 001d0000 and -1", {rx16(16), rx16(18)}, frame_diff());
        end
        exp_id = exp_id + 16'd1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_directed();
        wait_idle(ok);
        send_frame();
        for (int i = 0; i < 200 && rx_len() < 20; i++) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin failed++; $display("FAIL midreset_async: got valid %b data %h, want 0 00", out_valid, out_data); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_id = 16'h0000;
        wait_idle(ok);
        build_frame(exp_id);
        send_frame();
        wait_sent(ok);
        tests++;
        if (rx_len() != 50 || {rx16(18), rx16(24)} !== 32'h0000_26C7 || frame_diff() != -1) begin
            failed++;
            $display("FAIL midreset_frame: got %0d bytes id/csum %h diff %0d, want 50 000026c7 -1", rx_len(), {rx16(18), rx16(24)}, frame_diff());
        end
    endtask

    task automatic test_idle_rules();
        tests++;
        if (bad_idle != 0) begin failed++; $display("FAIL idle_data: got %0d nonzero idle bytes, want 0", bad_idle); end
        tests++;
        if (bad_fs != 0) begin failed++; $display("FAIL sent_overlap: got %0d frame_sent with out_valid, want 0", bad_fs); end
    endtask

    initial begin
        set_directed();
        test_reset();
        test_directed();
        test_back_to_back();
        test_max_payload();
        test_cfg_change();
        test_random();
        test_overflow();
        test_reset_mid();
        test_idle_rules();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/udp_packet_builder.md
Name: udp_packet_builder

Overview:
- Transmit-side counterpart to the UDP filter: collects a raw payload byte stream and emits a complete Ethernet II / IPv4 / UDP frame as a contiguous byte stream.
- Emitted frames are byte-for-byte parseable by the filter.
- Payload is buffered internally because the IP and UDP length fields (and IP checksum) precede the payload on the wire.
- Sits between an application payload source and the line-side byte stream.

Parameters:
- MAX_PAYLOAD, 32, payload buffer depth in bytes (1..255).
- IP_TTL, 8'h40, TTL byte placed in every IPv4 header.
- IFG_CYCLES, 4, idle cycles forced after each frame before the next frame may be collected.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  payload byte valid; a frame is the run of consecutive valid cycles, ending when in_valid deasserts.
- in_data  in  8  payload byte.
- in_ready  out  1  high when a byte presented with in_valid is accepted.
- cfg_dst_mac  in  48  destination MAC.
- cfg_src_mac  in  48  source MAC.
- cfg_src_ip  in  32  IPv4 source address.
- cfg_dst_ip  in  32  IPv4 destination address.
- cfg_src_port  in  16  UDP source port.
- cfg_dst_port  in  16  UDP destination port.
- out_valid  out  1  frame byte valid; contiguous for the whole frame, no backpressure.
- out_data  out  8  frame byte.
- tx_busy  out  1  high in any state other than IDLE.
- frame_sent  out  1  one-cycle pulse in the cycle after the last frame byte.
- overflow  out  1  one-cycle pulse when a frame is discarded for exceeding MAX_PAYLOAD.

Behaviour:
- Reset (async assert, sync release): state IDLE, out_valid=0, out_data=0, in_ready=1, tx_busy/frame_sent/overflow=0, ip_id=0, buffer count=0.
- IDLE: in_ready=1; first in_valid byte is written to buffer[0] and the block goes to COLLECT.
- COLLECT:
  - Each in_valid cycle writes buffer[N] and increments N.
  - On the first cycle with in_valid=0, go to CSUM and latch all cfg_* inputs and N.
  - If byte MAX_PAYLOAD+1 arrives, pulse overflow, go to DROP, and discard the frame.
- DROP: in_ready=1; ignore bytes until in_valid=0, then return to IDLE. No output is produced and ip_id is unchanged.
- CSUM (1 cycle):
  - Register the IPv4 header checksum: ones-complement of the end-around-carry sum of the ten header words, with the checksum field taken as 0.
  - in_ready=0 from CSUM through GAP.
- HEADER (42 cycles): out_valid=1, emitting bytes in this order:
  - dst_mac, src_mac, 08 00.
  - 45 00, total_len=28+N, ip_id, 40 00 (DF set, offset 0), IP_TTL, 11, checksum, src_ip, dst_ip.
  - src_port, dst_port, udp_len=8+N, udp_csum.
  - All multi-byte fields are emitted MSB first.
- PAYLOAD (N cycles): out_valid=1, emit buffer[0..N-1].
- End of frame: the next cycle after the last byte has out_valid=0 and out_data=0. frame_sent pulses and ip_id increments (16-bit wrap FFFF->0000).
- GAP: IFG_CYCLES idle cycles, then IDLE.
- Latency: out_valid rises exactly 2 rising edges after the edge that samples in_valid=0 ending COLLECT.
- Frame length is 42+N bytes.
- Zero-length payloads are not supported; a frame needs at least 1 byte.
- cfg_* changes after the latch point do not affect the frame in flight.
- out_data=0 whenever out_valid=0.
- Reset mid-frame: out_valid drops immediately (asynchronously), buffer contents are abandoned, and ip_id returns to 0.

Optional Feature:
- UDP_CHECKSUM_EN defined:
  - Accumulate a 17-bit end-around-carry sum of payload byte pairs during COLLECT; an odd final byte is padded low with 00.
  - In CSUM, add the pseudo-header words (src_ip, dst_ip, 0x0011, udp_len) and the UDP header words, then complement.
  - A result of 0000 is emitted as FFFF.
- Undefined: udp_csum field is 00 00 and no accumulator logic exists.

Decomposition:
- Package udp_tx_pkg holds:
  - ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, HDR_LEN=42.
  - ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11.
  - The state enum (IDLE, COLLECT, DROP, CSUM, HEADER, PAYLOAD, GAP).
  - A ones-complement add function.
- Sub-module udp_tx_payload_buf: MAX_PAYLOAD x 8 buffer with write pointer and count, plus read pointer.

Test Plan:
- Directed pass frame:
  - Stimulus: MACs FF:FF:FF:FF:FF:FF / 11:22:33:44:55:66, IPs 0A000001->0A000002, ports C0DE->04D2, payload DE AD BE EF FE ED CA FE.
  - Required: exactly 50 bytes; total_len 00 24, ip_id 00 00, checksum 26 C7, udp_len 00 10, udp_csum 00 00 (macro off).
  - Output is accepted by udp_packet_filter with match port 1234.
- Back-to-back: repeat the same payload after in_ready returns -> second frame ip_id 00 01, checksum 26 C6, and at least IFG_CYCLES idle cycles between frames.
- Overflow: 33 bytes with MAX_PAYLOAD=32 -> overflow pulse, no out_valid, next 1-byte frame gives total_len 00 1D and ip_id 00 00.
- Max payload: 32 bytes 00..1F -> 74-byte frame, udp_len 00 28, payload bytes in order.
- Config change: change cfg_dst_port to 04D3 during HEADER -> current frame still carries 04 D2; next frame carries 04 D3.
- Reset mid-frame: assert reset_n low at header byte 20 -> out_valid=0 immediately; a fresh 8-byte frame after release matches the first scenario with ip_id 00 00.
